change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: maximum cycles note_req may wait for note_ack before a jam is declared.
REQ-002 Parameter INV_W, default 8: width of each per-denomination inventory counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to dispense change_amount.
REQ-006 change_amount  input  10  change value in rupees, sampled on start.
REQ-007 load_inv  input  1  inventory write strobe.
REQ-008 load_sel  input  3  denomination index for the write: 0=10, 1=20, 2=50, 3=100, 4=200, 5=500.
REQ-009 load_count  input  INV_W  new note count for load_sel.
REQ-010 note_req  output  1  request to the ejector to eject one note.
REQ-011 note_denom  output  10  value of the note requested; 0 when note_req=0.
REQ-012 note_ack  input  1  ejector reports that the note has been ejected.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 error  output  1  one-cycle pulse on failure.
REQ-016 error_code  output  2  00 none, 01 bad amount, 10 insufficient notes, 11 jam; held until the next accepted start.
REQ-017 remaining  output  10  amount still to be ejected.

Function
REQ-018 States: IDLE, PLAN, EJECT, WAIT_ACK, DONE, FAIL.
REQ-019 In IDLE, start latches change_amount into remaining, clears error_code and the plan counters, then transitions:
- amount mod 10 != 0: to FAIL, code 01.
- amount 0: to DONE.
- otherwise: to PLAN.
REQ-020 PLAN allocates one note per cycle. Choose the largest denomination d with d <= residual and (inventory[d] - plan[d]) > 0, increment plan[d] and subtract d from residual.
REQ-021 PLAN ends when residual reaches 0 (go to EJECT) or no denomination qualifies while residual > 0 (go to FAIL, code 10). A failed plan ejects no notes and leaves inventory unchanged.
REQ-022 EJECT selects the largest d with plan[d] > 0, drives note_req=1 with note_denom=d, and enters WAIT_ACK. If all plan counters are 0, it goes to DONE.
REQ-023 In WAIT_ACK, note_req and note_denom hold stable until note_ack is sampled high.
REQ-024 On that ack cycle the block:
- drops note_req on the next cycle;
- decrements plan[d] and inventory[d];
- subtracts d from remaining;
- returns to EJECT.
Minimum spacing between requests is 2 cycles.
REQ-025 note_ack outside WAIT_ACK is ignored.
REQ-026 A per-request timer in WAIT_ACK that reaches ACK_TIMEOUT cycles without note_ack goes to FAIL with code 11. Notes already ejected stay deducted, and remaining shows the shortfall.
REQ-027 DONE pulses done for one cycle and returns to IDLE. FAIL pulses error for one cycle and returns to IDLE.
REQ-028 start while busy=1 is ignored.
REQ-029 load_inv is honoured only in IDLE and ignored otherwise. Simultaneous load_inv and start in IDLE: the load is applied and start is ignored.
REQ-030 Inventory decrement never underflows; PLAN guarantees inventory >= plan.

Reset
REQ-031 Asserting reset (low) at any time, including mid-eject, forces:
- state IDLE;
- note_req=0, note_denom=0, busy=0, done=0, error=0;
- error_code=00, remaining=0;
- all plan and inventory counters 0;
- timer 0.
REQ-032 The first action after reset deassertion is on the next rising clk edge.

Structure
REQ-033 A shared package holds:
- the denomination table (10, 20, 50, 100, 200, 500) and index constants;
- the state enum;
- the error_code constants;
- the default ACK_TIMEOUT.
REQ-034 One combinational sub-module, denom_select, returns the largest eligible denomination index and a found flag from residual and a per-denomination availability vector. It is used by both PLAN and EJECT.

Verification
REQ-035 Load 500:2, 200:2, 50:2, 20:2, 10:2; start with 780; ack each request in 1 cycle -> note_denom sequence 500, 200, 50, 20, 10, then done; inventory 500:1, 200:1, 50:1, 20:1, 10:1.
REQ-036 start with 75 -> error pulse, code 01, no note_req, remaining 75.
REQ-037 Inventory 500:1 only; start with 300 -> code 10, no note_req, inventory unchanged.
REQ-038 Inventory 100:3; start 300; never ack the second request, ACK_TIMEOUT=8 -> code 11 after 8 cycles, remaining 200, inventory 100:2.
REQ-039 Assert reset while note_req=1 -> all outputs return to reset values within the same cycle; a subsequent start with 0 -> done pulse after 2 cycles, no note_req.
REQ-040 start while busy, and load_inv during EJECT -> both ignored; the dispense sequence and inventory are unaffected.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: denomination table, FSM states,
// error codes and default timing.
`timescale 1ns/1ps
package change_dispenser_pkg;

   localparam int NUM_DENOM           = 6;
   localparam int AMT_W               = 10;
   localparam int IDX_W               = 3;
   localparam int DEFAULT_ACK_TIMEOUT = 255;

   localparam logic [IDX_W-1:0] IDX_10  = 3'd0;
   localparam logic [IDX_W-1:0] IDX_20  = 3'd1;
   localparam logic [IDX_W-1:0] IDX_50  = 3'd2;
   localparam logic [IDX_W-1:0] IDX_100 = 3'd3;
   localparam logic [IDX_W-1:0] IDX_200 = 3'd4;
   localparam logic [IDX_W-1:0] IDX_500 = 3'd5;

   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_BAD_AMOUNT = 2'b01;
   localparam logic [1:0] ERR_NO_NOTES   = 2'b10;
   localparam logic [1:0] ERR_JAM        = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAN,
      ST_EJECT,
      ST_WAIT_ACK,
      ST_DONE,
      ST_FAIL
   } state_t;

   // Index-to-value lookup; unused codes map to 0 so they never qualify as a note.
   function automatic logic [AMT_W-1:0] denom_value(input logic [IDX_W-1:0] idx);
      case (idx)
         IDX_10:  return 10'd10;
         IDX_20:  return 10'd20;
         IDX_50:  return 10'd50;
         IDX_100: return 10'd100;
         IDX_200: return 10'd200;
         IDX_500: return 10'd500;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_denom_select.sv
// Combinational picker: largest denomination index that is available and does
// not exceed the residual amount.
`timescale 1ns/1ps
module denom_select
   import change_dispenser_pkg::*;
(
   input  logic [AMT_W-1:0]     residual,
   input  logic [NUM_DENOM-1:0] avail,
   output logic [IDX_W-1:0]     idx,
   output logic                 found
);

   logic [NUM_DENOM-1:0] eligible;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DENOM; gi++) begin : g_elig
         assign eligible[gi] = avail[gi] && (denom_value(IDX_W'(gi)) <= residual);
      end
   endgenerate

   // Ascending scan, so the highest eligible index is the one that sticks.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_DENOM; i++) begin
         if (eligible[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: plans a greedy note allocation against inventory, then
// ejects the notes one at a time through a request/acknowledge handshake.
`timescale 1ns/1ps
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter int INV_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] change_amount,
   input  logic             load_inv,
   input  logic [IDX_W-1:0] load_sel,
   input  logic [INV_W-1:0] load_count,
   output logic             note_req,
   output logic [AMT_W-1:0] note_denom,
   input  logic             note_ack,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       error_code,
   output logic [AMT_W-1:0] remaining
);

   localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   state_t             state_reg;
   logic [INV_W-1:0]   inv_reg  [NUM_DENOM];
   logic [INV_W-1:0]   plan_reg [NUM_DENOM];
   logic [AMT_W-1:0]   residual_reg;
   logic [IDX_W-1:0]   cur_idx_reg;
   logic [TMR_W-1:0]   timer_reg;

   logic [NUM_DENOM-1:0] plan_avail;
   logic [NUM_DENOM-1:0] eject_avail;
   logic [NUM_DENOM-1:0] sel_avail;
   logic [AMT_W-1:0]     sel_residual;
   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_found;
   logic [AMT_W-1:0]     sel_denom;
   logic [AMT_W-1:0]     cur_denom;
   logic                 amount_bad;

   // inventory never drops below plan, so inequality means at least one spare note
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DENOM; gi++) begin : g_avail
         assign plan_avail[gi]  = (inv_reg[gi] != plan_reg[gi]);
         assign eject_avail[gi] = (plan_reg[gi] != '0);
      end
   endgenerate

   // EJECT ignores value limits, so it presents an all-ones residual.
   assign sel_residual = (state_reg == ST_PLAN) ? residual_reg : '1;
   assign sel_avail    = (state_reg == ST_PLAN) ? plan_avail : eject_avail;

   denom_select u_denom_select (
      .residual (sel_residual),
      .avail    (sel_avail),
      .idx      (sel_idx),
      .found    (sel_found)
   );

   assign sel_denom  = denom_value(sel_idx);
   assign cur_denom  = denom_value(cur_idx_reg);
   assign amount_bad = ((change_amount % 10'd10) != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         residual_reg <= '0;
         cur_idx_reg  <= '0;
         timer_reg    <= '0;
         note_req     <= 1'b0;
         note_denom   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         error_code   <= ERR_NONE;
         remaining    <= '0;
         for (int i = 0; i < NUM_DENOM; i++) begin
            inv_reg[i]  <= '0;
            plan_reg[i] <= '0;
         end
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (load_inv) begin
                  if (load_sel <= IDX_500) inv_reg[load_sel] <= load_count;
               end else if (start) begin
                  remaining    <= change_amount;
                  residual_reg <= change_amount;
                  error_code   <= ERR_NONE;
                  busy         <= 1'b1;
                  for (int i = 0; i < NUM_DENOM; i++) plan_reg[i] <= '0;
                  if (amount_bad) begin
                     error_code <= ERR_BAD_AMOUNT;
                     state_reg  <= ST_FAIL;
                  end else if (change_amount == '0) begin
                     state_reg <= ST_DONE;
                  end else begin
                     state_reg <= ST_PLAN;
                  end
               end
            end

            ST_PLAN: begin
               if (sel_found) begin
                  plan_reg[sel_idx] <= plan_reg[sel_idx] + INV_W'(1);
                  residual_reg      <= residual_reg - sel_denom;
                  if (residual_reg == sel_denom) state_reg <= ST_EJECT;
               end else begin
                  error_code <= ERR_NO_NOTES;
                  state_reg  <= ST_FAIL;
               end
            end

            ST_EJECT: begin
               if (sel_found) begin
                  note_req    <= 1'b1;
                  note_denom  <= sel_denom;
                  cur_idx_reg <= sel_idx;
                  timer_reg   <= '0;
                  state_reg   <= ST_WAIT_ACK;
               end else begin
                  state_reg <= ST_DONE;
               end
            end

            ST_WAIT_ACK: begin
               if (note_ack) begin
                  note_req              <= 1'b0;
                  note_denom            <= '0;
                  plan_reg[cur_idx_reg] <= plan_reg[cur_idx_reg] - INV_W'(1);
                  inv_reg[cur_idx_reg]  <= inv_reg[cur_idx_reg] - INV_W'(1);
                  remaining             <= remaining - cur_denom;
                  state_reg             <= ST_EJECT;
               end else if (timer_reg == TMR_LAST) begin
                  note_req   <= 1'b0;
                  note_denom <= '0;
                  error_code <= ERR_JAM;
                  state_reg  <= ST_FAIL;
               end else begin
                  timer_reg <= timer_reg + TMR_W'(1);
               end
            end

            ST_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end

            ST_FAIL: begin
               error     <= 1'b1;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: dispense, bad amount, shortage, jam,
// mid-eject reset and ignored start/load while busy.
`timescale 1ns/1ps
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [9:0] change_amount = '0;
   logic       load_inv = 1'b0;
   logic [2:0] load_sel = '0;
   logic [7:0] load_count = '0;
   logic       note_req;
   logic [9:0] note_denom;
   logic       note_ack = 1'b0;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] error_code;
   logic [9:0] remaining;

   int n_checks = 0;
   int n_fail   = 0;

   int denoms[$];
   bit seen_done;
   bit seen_err;
   int last_req_cycles;
   bit denom_idle_ok;

   change_dispenser #(.ACK_TIMEOUT(8), .INV_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .change_amount (change_amount),
      .load_inv      (load_inv),
      .load_sel      (load_sel),
      .load_count    (load_count),
      .note_req      (note_req),
      .note_denom    (note_denom),
      .note_ack      (note_ack),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .error_code    (error_code),
      .remaining     (remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic load(input logic [2:0] sel, input logic [7:0] cnt);
      @(negedge clk);
      load_inv   = 1'b1;
      load_sel   = sel;
      load_count = cnt;
      @(negedge clk);
      load_inv = 1'b0;
   endtask

   // Runs one dispense; acks the first ack_limit requests one cycle after they
   // rise, and optionally injects a start+load at sample cycle inject_cyc.
   task automatic dispense(input logic [9:0] amt, input int ack_limit, input int inject_cyc);
      int  cyc;
      int  acks;
      bit  prev_req;
      denoms.delete();
      seen_done       = 1'b0;
      seen_err        = 1'b0;
      last_req_cycles = 0;
      denom_idle_ok   = 1'b1;
      acks            = 0;
      prev_req        = 1'b0;
      cyc             = 0;
      @(negedge clk);
      change_amount = amt;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen_done && !seen_err && cyc < 300) begin
         note_ack = 1'b0;
         load_inv = 1'b0;
         start    = 1'b0;
         if (done)  seen_done = 1'b1;
         if (error) seen_err  = 1'b1;
         if (note_req) begin
            if (!prev_req) begin
               denoms.push_back(int'(note_denom));
               last_req_cycles = 0;
               if (acks < ack_limit) begin
                  note_ack = 1'b1;
                  acks++;
               end
            end
            last_req_cycles++;
         end else if (note_denom != '0) begin
            denom_idle_ok = 1'b0;
         end
         if (cyc == inject_cyc) begin
            start         = 1'b1;
            change_amount = 10'd10;
            load_inv      = 1'b1;
            load_sel      = 3'd3;
            load_count    = 8'd9;
         end
         prev_req = note_req;
         cyc++;
         if (!seen_done && !seen_err) @(negedge clk);
      end
      note_ack = 1'b0;
      load_inv = 1'b0;
      start    = 1'b0;
      check("dispense_finished", 32'(seen_done | seen_err), 1);
      check("denom_zero_when_idle", 32'(denom_idle_ok), 1);
      $display("dispense amt=%0d notes=%0d done=%0d error=%0d code=%0d remaining=%0d",
               amt, denoms.size(), seen_done, seen_err, error_code, remaining);
   endtask

   int exp780[5] = '{500, 200, 50, 20, 10};

   initial begin
      int wait_cyc;

      // Reset state
      do_reset();
      check("rst_note_req", 32'(note_req), 0);
      check("rst_note_denom", 32'(note_denom), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done_error", 32'({done, error}), 0);
      check("rst_error_code", 32'(error_code), 0);
      check("rst_remaining", 32'(remaining), 0);

      // Greedy dispense of 780 using one of each denomination except 100
      load(3'd5, 8'd2);
      load(3'd4, 8'd2);
      load(3'd2, 8'd2);
      load(3'd1, 8'd2);
      load(3'd0, 8'd2);
      dispense(10'd780, 100, -1);
      check("d780_count", 32'(denoms.size()), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("d780_note%0d", i), (i < denoms.size()) ? 32'(denoms[i]) : 32'hFFFF_FFFF, 32'(exp780[i]));
      check("d780_done", 32'(seen_done), 1);
      check("d780_code", 32'(error_code), 0);
      check("d780_remaining", 32'(remaining), 0);
      check("d780_inv500", 32'(dut.inv_reg[5]), 1);
      check("d780_inv200", 32'(dut.inv_reg[4]), 1);
      check("d780_inv100", 32'(dut.inv_reg[3]), 0);
      check("d780_inv50", 32'(dut.inv_reg[2]), 1);
      check("d780_inv20", 32'(dut.inv_reg[1]), 1);
      check("d780_inv10", 32'(dut.inv_reg[0]), 1);

      // Amount not a multiple of 10
      dispense(10'd75, 100, -1);
      check("d75_error", 32'(seen_err), 1);
      check("d75_code", 32'(error_code), 1);
      check("d75_notes", 32'(denoms.size()), 0);
      check("d75_remaining", 32'(remaining), 75);

      // Shortage: only one 500 note for 300
      do_reset();
      load(3'd5, 8'd1);
      dispense(10'd300, 100, -1);
      check("d300_error", 32'(seen_err), 1);
      check("d300_code", 32'(error_code), 2);
      check("d300_notes", 32'(denoms.size()), 0);
      check("d300_inv500", 32'(dut.inv_reg[5]), 1);
      repeat (3) @(negedge clk);
      check("d300_code_held", 32'(error_code), 2);

      // Zero amount completes and clears the held error code
      dispense(10'd0, 100, -1);
      check("d0_done", 32'(seen_done), 1);
      check("d0_code_cleared", 32'(error_code), 0);
      check("d0_notes", 32'(denoms.size()), 0);

      // Jam: second note never acknowledged
      do_reset();
      load(3'd3, 8'd3);
      dispense(10'd300, 1, -1);
      check("jam_error", 32'(seen_err), 1);
      check("jam_code", 32'(error_code), 3);
      check("jam_notes", 32'(denoms.size()), 2);
      check("jam_req_cycles", 32'(last_req_cycles), 8);
      check("jam_remaining", 32'(remaining), 200);
      check("jam_inv100", 32'(dut.inv_reg[3]), 2);

      // Start and load while busy are ignored
      do_reset();
      load(3'd3, 8'd3);
      dispense(10'd300, 100, 3);
      check("busy_ign_count", 32'(denoms.size()), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("busy_ign_note%0d", i), (i < denoms.size()) ? 32'(denoms[i]) : 32'hFFFF_FFFF, 100);
      check("busy_ign_done", 32'(seen_done), 1);
      check("busy_ign_inv100", 32'(dut.inv_reg[3]), 0);
      repeat (3) @(negedge clk);
      check("busy_ign_idle", 32'({busy, note_req}), 0);

      // Asynchronous reset while a note request is outstanding
      do_reset();
      load(3'd3, 8'd1);
      @(negedge clk);
      change_amount = 10'd100;
      start         = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_cyc = 0;
      while (!note_req && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("mid_rst_req_seen", 32'(note_req), 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_note_req", 32'(note_req), 0);
      check("mid_rst_note_denom", 32'(note_denom), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done_error", 32'({done, error}), 0);
      check("mid_rst_code", 32'(error_code), 0);
      check("mid_rst_remaining", 32'(remaining), 0);
      check("mid_rst_inv100", 32'(dut.inv_reg[3]), 0);
      $display("reset asserted mid-eject at %0t", $time);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      change_amount = 10'd0;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("post_rst_cycle1_done", 32'(done), 0);
      check("post_rst_cycle1_busy", 32'(busy), 1);
      @(negedge clk);
      check("post_rst_cycle2_done", 32'(done), 1);
      check("post_rst_cycle2_busy", 32'(busy), 0);
      check("post_rst_no_req", 32'(note_req), 0);
      $display("zero-amount start after reset: done=%0d", done);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
